// File: rtl/fifo_block_ctrl.sv
// Store-and-forward block mover: fills one block from the DMA side into the FIFO,
// then drains that block to the SD side, repeating for the requested block count.
//
// state  | meaning
// IDLE   | waiting for start; rejects zero-sized requests with err
// FILL   | writing DMA words into the FIFO until one block is stored
// DRAIN  | reading the stored block out to the SD side
// FINISH | all blocks moved; done pulses for this one cycle
`timescale 1ns/1ps
module fifo_block_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET_L,
    input  logic              start,
    input  logic [CNT_W-1:0]  blk_words,
    input  logic [CNT_W-1:0]  blk_count,
    input  logic              abort,
    input  logic [DATA_W-1:0] dma_data,
    input  logic              dma_valid,
    output logic              dma_ready,
    output logic [DATA_W-1:0] fifo_data,
    output logic              fifo_write,
    output logic              fifo_read,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic              sd_ready,
    output logic              sd_valid,
    output logic              busy,
    output logic              blk_done,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic [CNT_W-1:0]   words_q;
    logic [CNT_W-1:0]   blk_left_q;
    logic               sd_valid_q;
    logic               blk_done_q;
    logic               err_q;

    logic               in_fill;
    logic               in_drain;
    logic               wr;
    logic               rd;
    logic [CNT_W-1:0]   word_nxt;
    logic               last_word;

    assign in_fill   = (state_q == S_FILL);
    assign in_drain  = (state_q == S_DRAIN);
    // abort gates the strobes so nothing moves in the cycle the transfer is dropped
    assign wr        = in_fill  & dma_valid & ~fifo_full  & ~abort;
    assign rd        = in_drain & sd_ready  & ~fifo_empty & ~abort;
    assign word_nxt  = word_cnt_q + CNT_ONE;
    assign last_word = (word_nxt == words_q);

    assign dma_ready  = in_fill & ~fifo_full & ~abort;
    assign fifo_write = wr;
    assign fifo_read  = rd;
    assign fifo_data  = in_fill ? dma_data : '0;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FINISH) & ~abort;
    assign sd_valid   = sd_valid_q;
    assign blk_done   = blk_done_q;
    assign err        = err_q;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            words_q    <= '0;
            blk_left_q <= '0;
            sd_valid_q <= 1'b0;
            blk_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sd_valid_q <= rd;
            blk_done_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        if ((blk_words != '0) && (blk_count != '0)) begin
                            words_q    <= blk_words;
                            blk_left_q <= blk_count;
                            word_cnt_q <= '0;
                            state_q    <= S_FILL;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (abort) begin
                        word_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end else if (wr) begin
                        if (last_word) begin
                            word_cnt_q <= '0;
                            state_q    <= S_DRAIN;
                        end else begin
                            word_cnt_q <= word_nxt;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        word_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end else if (rd) begin
                        if (last_word) begin
                            word_cnt_q <= '0;
                            blk_left_q <= blk_left_q - CNT_ONE;
                            blk_done_q <= 1'b1;
                            state_q    <= (blk_left_q == CNT_ONE) ? S_FINISH : S_FILL;
                        end else begin
                            word_cnt_q <= word_nxt;
                        end
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_block_ctrl.sv
// Bench for fifo_block_ctrl: a cycle-by-cycle vector table with hand-computed outputs,
// followed by whole-transfer sequences for the multi-cycle and reset corner cases.
`timescale 1ns/1ps
module tb_fifo_block_ctrl;

    logic        CLK;
    logic        RESET_L;
    logic        start;
    logic [15:0] blk_words;
    logic [15:0] blk_count;
    logic        abort;
    logic [31:0] dma_data;
    logic        dma_valid;
    logic        dma_ready;
    logic [31:0] fifo_data;
    logic        fifo_write;
    logic        fifo_read;
    logic        fifo_full;
    logic        fifo_empty;
    logic        sd_ready;
    logic        sd_valid;
    logic        busy;
    logic        blk_done;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    fifo_block_ctrl #(.DATA_W(32), .CNT_W(16)) dut (
        .CLK(CLK), .RESET_L(RESET_L), .start(start), .blk_words(blk_words),
        .blk_count(blk_count), .abort(abort), .dma_data(dma_data), .dma_valid(dma_valid),
        .dma_ready(dma_ready), .fifo_data(fifo_data), .fifo_write(fifo_write),
        .fifo_read(fifo_read), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .sd_ready(sd_ready), .sd_valid(sd_valid), .busy(busy), .blk_done(blk_done),
        .done(done), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {dma_ready, fifo_write, fifo_read, sd_valid, busy, blk_done, done, err}
    logic [7:0] outs;
    assign outs = {dma_ready, fifo_write, fifo_read, sd_valid, busy, blk_done, done, err};

    typedef struct {
        logic        st;
        logic [15:0] bw;
        logic [15:0] bc;
        logic        ab;
        logic        dv;
        logic        ff;
        logic        fe;
        logic        sr;
        logic [31:0] dd;
        logic [7:0]  ex;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input int bw, input int bc, input logic ab,
                                input logic dv, input logic ff, input logic fe, input logic sr,
                                input logic [31:0] dd, input logic [7:0] ex, input logic [31:0] ed);
        vec_t v;
        v.st = st; v.bw = bw[15:0]; v.bc = bc[15:0]; v.ab = ab; v.dv = dv;
        v.ff = ff; v.fe = fe; v.sr = sr; v.dd = dd; v.ex = ex; v.ed = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 0; blk_words = 0; blk_count = 0; abort = 0; dma_data = 0;
        dma_valid = 0; fifo_full = 0; fifo_empty = 0; sd_ready = 0;
    endtask

    // Runs one transfer to completion with free-flowing FIFO flags and tallies events.
    // nbad counts overlaps, pass-through data errors, sd_valid misalignment and misplaced blk_done.
    task automatic run_xfer(input int bw, input int bc, input bit tog,
                            output int nwr, output int nrd, output int nsv,
                            output int nbd, output int ndn, output int nbad);
        logic prev_rd;
        nwr = 0; nrd = 0; nsv = 0; nbd = 0; ndn = 0; nbad = 0;
        idle_inputs();
        start = 1; blk_words = bw[15:0]; blk_count = bc[15:0];
        @(posedge CLK); #1;
        start = 0;
        prev_rd = 0;
        for (int cyc = 0; cyc < 200 && ndn == 0; cyc++) begin
            dma_valid = 1;
            dma_data  = 32'hD000_0000 + nwr;
            sd_ready  = tog ? cyc[0] : 1'b1;
            @(negedge CLK);
            if (fifo_write && fifo_read) nbad++;
            if (fifo_write && fifo_data !== 32'hD000_0000 + nwr) nbad++;
            if (sd_valid !== prev_rd) nbad++;
            if (blk_done && (nwr != bw * (nbd + 1) || nrd != bw * (nbd + 1))) nbad++;
            if (fifo_write) nwr++;
            if (fifo_read)  nrd++;
            if (sd_valid)   nsv++;
            if (blk_done)   nbd++;
            if (done)       ndn++;
            prev_rd = fifo_read;
            @(posedge CLK); #1;
        end
    endtask

    localparam logic [31:0] A1 = 32'hA000_0001, A2 = 32'hA000_0002;
    localparam logic [31:0] A3 = 32'hA000_0003, A4 = 32'hA000_0004;
    localparam logic [31:0] B1 = 32'hB000_0001, B2 = 32'hB000_0002, B3 = 32'hB000_0003;
    localparam logic [31:0] C1 = 32'hC000_0001, D1 = 32'hD100_0001;

    int nwr, nrd, nsv, nbd, ndn, nbad;

    initial begin
        //                st bw bc ab dv ff fe sr data  outs          fifo_data
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  8'b0000_0000, 0));
        vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0,  8'b0000_0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  8'b0000_0001, 0));
        vecs.push_back(mk(1, 2, 2, 1, 0, 0, 0, 0, 0,  8'b0000_0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  8'b0000_0000, 0));
        vecs.push_back(mk(1, 2, 2, 0, 1, 0, 0, 0, A1, 8'b0000_0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, A1, 8'b1100_1000, A1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, A2, 8'b1100_1000, A2));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, A2, 8'b0010_1000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, A2, 8'b0011_1000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, A3, 8'b0001_1100, A3));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, A3, 8'b0000_1000, A3));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, A3, 8'b0000_1000, A3));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, A3, 8'b1100_1000, A3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, A4, 8'b1000_1000, A4));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, A4, 8'b1100_1000, A4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  8'b0000_1000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0,  8'b0000_1000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  8'b0010_1000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  8'b0011_1000, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 0,  8'b0001_1110, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  8'b0000_0000, 0));
        vecs.push_back(mk(1, 4, 1, 0, 1, 0, 0, 0, B1, 8'b0000_0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, B1, 8'b1100_1000, B1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, B2, 8'b1100_1000, B2));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, B3, 8'b0000_1000, B3));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, B3, 8'b0000_0000, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 1, C1, 8'b0000_0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, C1, 8'b1100_1000, C1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, C1, 8'b0010_1000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  8'b0001_1110, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  8'b0000_0000, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 1, D1, 8'b0000_0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, D1, 8'b1100_1000, D1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  8'b0010_1000, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,  8'b0001_1100, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  8'b0000_0000, 0));

        idle_inputs();
        RESET_L = 0;
        dma_valid = 1; dma_data = 32'h1234_5678;
        #3;
        check("reset outs", {24'h0, outs}, 0);
        check("reset data", fifo_data, 0);
        dma_valid = 0; dma_data = 0;
        repeat (2) @(posedge CLK);
        #1 RESET_L = 1;

        foreach (vecs[i]) begin
            start = vecs[i].st; blk_words = vecs[i].bw; blk_count = vecs[i].bc;
            abort = vecs[i].ab; dma_valid = vecs[i].dv; fifo_full = vecs[i].ff;
            fifo_empty = vecs[i].fe; sd_ready = vecs[i].sr; dma_data = vecs[i].dd;
            @(negedge CLK);
            check($sformatf("vec%0d outs", i), {24'h0, outs}, {24'h0, vecs[i].ex});
            check($sformatf("vec%0d data", i), fifo_data, vecs[i].ed);
            @(posedge CLK); #1;
        end

        // 4 words x 2 blocks, free flowing
        run_xfer(4, 2, 0, nwr, nrd, nsv, nbd, ndn, nbad);
        check("basic writes", nwr, 8);
        check("basic reads", nrd, 8);
        check("basic sd_valid", nsv, 8);
        check("basic blk_done", nbd, 2);
        check("basic done", ndn, 1);
        check("basic order", nbad, 0);

        // 1 word x 3 blocks with sd_ready toggling
        run_xfer(1, 3, 1, nwr, nrd, nsv, nbd, ndn, nbad);
        check("edge writes", nwr, 3);
        check("edge reads", nrd, 3);
        check("edge blk_done", nbd, 3);
        check("edge done", ndn, 1);
        check("edge order", nbad, 0);

        // reset in the middle of DRAIN
        idle_inputs();
        start = 1; blk_words = 2; blk_count = 1; dma_valid = 1; sd_ready = 1;
        dma_data = 32'h5555_0000;
        @(posedge CLK); #1;
        start = 0;
        repeat (3) begin @(posedge CLK); #1; end
        check("pre-reset read", fifo_read, 1);
        check("pre-reset sd_valid", sd_valid, 1);
        #2 RESET_L = 0;
        #1;
        check("async reset outs", {24'h0, outs}, 0);
        check("async reset data", fifo_data, 0);
        @(posedge CLK); #1;
        check("held reset outs", {24'h0, outs}, 0);
        RESET_L = 1;
        @(posedge CLK); #1;
        check("after reset idle", {24'h0, outs}, 0);
        run_xfer(1, 1, 0, nwr, nrd, nsv, nbd, ndn, nbad);
        check("post-reset writes", nwr, 1);
        check("post-reset blk_done", nbd, 1);
        check("post-reset done", ndn, 1);
        check("post-reset order", nbad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
